// File: rtl/ad_ser_pkg.sv
// Shared constants, state encoding and frame packing for the AD serial transmitter.
package ad_ser_pkg;

    localparam int NCH        = 8;
    localparam int CH_W       = 24;
    localparam int FRAME_BITS = NCH * CH_W;
    localparam int BCNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [FRAME_BITS-1:0]      frame_t;
    typedef logic [BCNT_W-1:0]          bcnt_t;
    typedef logic [NCH-1:0][CH_W-1:0]   ch_arr_t;

    localparam bcnt_t LAST_BIT = bcnt_t'(FRAME_BITS - 1);

    // Channel 0 (CH1) lands in the MSBs so the frame shifts out CH1[23] first.
    function automatic frame_t pack_frame(input ch_arr_t ch);
        frame_t f;
        f = '0;
        for (int k = 0; k < NCH; k++)
            f[FRAME_BITS-1-k*CH_W -: CH_W] = ch[k];
        return f;
    endfunction

endpackage

// File: rtl/ad_clk_gen.sv
// ad_clk phase divider: low for HALF_DIV cycles, then high for HALF_DIV cycles, while run is high.
module ad_clk_gen #(
    parameter int HALF_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic ad_clk,
    output logic fall_en,
    output logic rise_end
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] PH_LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] ph_cnt;
    logic          ph_end;

    assign ph_end   = (ph_cnt == PH_LAST);
    assign fall_en  = run & ~ad_clk & (ph_cnt == '0);
    assign rise_end = run &  ad_clk & ph_end;

    // Holding the divider cleared while run is low makes every run rise start a fresh low phase.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            ph_cnt <= '0;
            ad_clk <= 1'b0;
        end else if (ph_end) begin
            ph_cnt <= '0;
            ad_clk <= ~ad_clk;
        end else begin
            ph_cnt <= ph_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ad_ser_ch.sv
// 8-channel x 24-bit parallel-to-serial AD frame transmitter with a one-deep pending buffer.
module ad_ser_ch
    import ad_ser_pkg::*;
#(
    parameter int HALF_DIV  = 1,
    parameter int READY_CYC = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [CH_W-1:0] data_CH1,
    input  logic [CH_W-1:0] data_CH2,
    input  logic [CH_W-1:0] data_CH3,
    input  logic [CH_W-1:0] data_CH4,
    input  logic [CH_W-1:0] data_CH5,
    input  logic [CH_W-1:0] data_CH6,
    input  logic [CH_W-1:0] data_CH7,
    input  logic [CH_W-1:0] data_CH8,
    output logic            busy,
    output logic            frame_done,
    output logic            overrun,
    output logic            ad_ready,
    output logic            ad_clk,
    output logic            ad_data
);

    localparam int RC_W = (READY_CYC > 1) ? $clog2(READY_CYC) : 1;
    localparam logic [RC_W-1:0] RDY_LAST = RC_W'(READY_CYC - 1);

    state_t          state, state_nxt;
    ch_arr_t         ch;
    frame_t          din, shreg, pend;
    logic            pend_vld;
    bcnt_t           bit_cnt;
    logic [RC_W-1:0] rdy_cnt;
    logic            rdy_last;
    logic            run, fall_en, rise_end;
    logic            ld_din, ld_pend, cap_pend, drop;

    assign ch       = {data_CH8, data_CH7, data_CH6, data_CH5,
                       data_CH4, data_CH3, data_CH2, data_CH1};
    assign din      = pack_frame(ch);
    assign rdy_last = (rdy_cnt == RDY_LAST);
    assign run      = (state == SHIFT);

    ad_clk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .ad_clk   (ad_clk),
        .fall_en  (fall_en),
        .rise_end (rise_end)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_din    = 1'b0;
        ld_pend   = 1'b0;
        cap_pend  = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    ld_din    = 1'b1;
                    state_nxt = READY;
                end
            end
            READY: begin
                if (rdy_last) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (rise_end && bit_cnt == LAST_BIT) state_nxt = DONE;
            end
            DONE: begin
                if (pend_vld) begin
                    ld_pend   = 1'b1;
                    state_nxt = READY;
                end else if (load) begin
                    ld_din    = 1'b1;
                    state_nxt = READY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A pending slot being drained this cycle is free for a simultaneous load.
        if (load && state != IDLE && !ld_din) begin
            if (!pend_vld || ld_pend) cap_pend = 1'b1;
            else                      drop     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            pend       <= '0;
            pend_vld   <= 1'b0;
            bit_cnt    <= '0;
            rdy_cnt    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            ad_ready   <= 1'b0;
            ad_data    <= 1'b0;
        end else begin
            busy       <= (state_nxt != IDLE);
            frame_done <= (state_nxt == DONE);
            overrun    <= drop;
            ad_ready   <= (state_nxt == READY);

            // shreg MSB always holds the bit to present at the next low phase.
            if (ld_din)       shreg <= din;
            else if (ld_pend) shreg <= pend;
            else if (fall_en) shreg <= shreg << 1;

            if (cap_pend) begin
                pend     <= din;
                pend_vld <= 1'b1;
            end else if (ld_pend) begin
                pend_vld <= 1'b0;
            end

            if (state == READY) rdy_cnt <= rdy_cnt + 1'b1;
            else                rdy_cnt <= '0;

            if (state != SHIFT) bit_cnt <= '0;
            else if (rise_end)  bit_cnt <= bit_cnt + 1'b1;

            if (state == READY && rdy_last)
                ad_data <= shreg[FRAME_BITS-1];
            else if (rise_end)
                ad_data <= (bit_cnt == LAST_BIT) ? 1'b0 : shreg[FRAME_BITS-1];
            else if (state != SHIFT)
                ad_data <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ad_ser_ch.sv
// Scoreboard bench for ad_ser_ch: default-timing instance plus a HALF_DIV=3/READY_CYC=1 instance.
module tb_ad_ser_ch;

    localparam int RC = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        load0 = 1'b0;
    logic        load1 = 1'b0;
    logic [23:0] ch [8];

    logic busy0, fd0, ovr0, rdy0, aclk0, adat0;
    logic busy1, fd1, ovr1, rdy1, aclk1, adat1;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic rst_s = 1'b1;
    bit   exp_q [$];

    int   rises = 0, rdy_len = 0, rdy_start = 0, done_cyc = 0, frames = 0, n_ovr = 0;
    logic p_clk = 1'b0, p_rdy = 1'b0, p_dat = 1'b0;

    ad_ser_ch #(.HALF_DIV(1), .READY_CYC(RC)) dut (
        .clk(clk), .reset(reset), .load(load0),
        .data_CH1(ch[0]), .data_CH2(ch[1]), .data_CH3(ch[2]), .data_CH4(ch[3]),
        .data_CH5(ch[4]), .data_CH6(ch[5]), .data_CH7(ch[6]), .data_CH8(ch[7]),
        .busy(busy0), .frame_done(fd0), .overrun(ovr0),
        .ad_ready(rdy0), .ad_clk(aclk0), .ad_data(adat0)
    );

    ad_ser_ch #(.HALF_DIV(3), .READY_CYC(1)) dut3 (
        .clk(clk), .reset(reset), .load(load1),
        .data_CH1(ch[0]), .data_CH2(ch[1]), .data_CH3(ch[2]), .data_CH4(ch[3]),
        .data_CH5(ch[4]), .data_CH6(ch[5]), .data_CH7(ch[6]), .data_CH8(ch[7]),
        .busy(busy1), .frame_done(fd1), .overrun(ovr1),
        .ad_ready(rdy1), .ad_clk(aclk1), .ad_data(adat1)
    );

    always #50 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= reset;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor for the default instance, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (rst_s) begin
            rises   = 0;
            rdy_len = 0;
        end else begin
            if (rdy0) begin
                if (!p_rdy) rdy_start = cyc;
                rdy_len++;
            end
            if (!rdy0 && p_rdy) begin
                chk("rdy_len", rdy_len, RC);
                rdy_len = 0;
            end
            if (aclk0 && !p_clk) begin
                if (rises == 0) chk("first_rise", cyc - rdy_start, RC + 1);
                rises++;
                if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
                else chk("bit", adat0, exp_q.pop_front());
            end
            if (adat0 != p_dat && !(p_clk && !aclk0) && !(p_rdy && !rdy0))
                chk("data_edge", adat0, p_dat);
            if (fd0) begin
                chk("rises", rises, 192);
                done_cyc = cyc;
                frames++;
                rises = 0;
            end
            if (ovr0) n_ovr++;
        end
        p_clk = aclk0;
        p_rdy = rdy0;
        p_dat = adat0;
    end

    initial begin
        #(100 * 40000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #10;
    endtask

    function automatic logic [191:0] frame_of();
        return {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], ch[6], ch[7]};
    endfunction

    task automatic push_frame(input logic [191:0] f);
        for (int i = 191; i >= 0; i--) exp_q.push_back(f[i]);
    endtask

    task automatic rnd_ch();
        for (int k = 0; k < 8; k++) ch[k] = 24'($urandom);
    endtask

    task automatic send0();
        push_frame(frame_of());
        load0 = 1'b1;
        tick();
        load0 = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int bound);
        int k = 0;
        while (frames < target && k < bound) begin
            tick();
            k++;
        end
        if (frames < target) chk("timeout", frames, target);
    endtask

    initial begin
        int n, f0, o0, d, k;
        int nr, last_rise, bad_edge, done_at;
        logic pc, pr, pd;
        logic [191:0] f;

        for (int i = 0; i < 8; i++) ch[i] = '0;
        repeat (3) tick();
        chk("rst_busy", busy0, 0);
        chk("rst_done", fd0, 0);
        chk("rst_ovr", ovr0, 0);
        chk("rst_rdy", rdy0, 0);
        chk("rst_clk", aclk0, 0);
        chk("rst_dat", adat0, 0);
        reset = 1'b0;
        tick();

        // Single frame, fixed pattern
        ch[0] = 24'hA5A5A5; ch[1] = 24'h5A5A5A; ch[2] = 24'hFFFFFF; ch[3] = 24'h000000;
        ch[4] = 24'h123456; ch[5] = 24'h800000; ch[6] = 24'hC3C3C3; ch[7] = 24'h000001;
        n = cyc;
        send0();
        chk("busy_on", busy0, 1);
        wait_frames(1, 600);
        chk("done_lat", done_cyc - n, 389);
        chk("idle_busy", busy0, 0);

        // Loopback-style pattern
        for (int i = 0; i < 8; i++) ch[i] = 24'h100000 + 24'(i + 1);
        send0();
        wait_frames(2, 600);

        // Mid-frame load into pending, third load dropped
        f0 = frames;
        o0 = n_ovr;
        rnd_ch();
        send0();
        repeat (200) tick();
        rnd_ch();
        send0();
        repeat (50) tick();
        rnd_ch();
        load0 = 1'b1;
        tick();
        load0 = 1'b0;
        chk("ovr_pulse", ovr0, 1);
        tick();
        chk("ovr_once", ovr0, 0);
        wait_frames(f0 + 1, 600);
        d = done_cyc;
        chk("b2b_rdy", rdy0, 1);
        tick();
        chk("gap", rdy_start - d, 1);
        wait_frames(f0 + 2, 800);
        repeat (20) tick();
        chk("no_third", frames, f0 + 2);
        chk("sb_drain", exp_q.size(), 0);
        chk("ovr_cnt", n_ovr, o0 + 1);
        chk("busy_end", busy0, 0);

        // Reset around bit 100, with a load in the reset cycle
        rnd_ch();
        send0();
        k = 0;
        while (rises < 100 && k < 1000) begin
            tick();
            k++;
        end
        rnd_ch();
        reset = 1'b1;
        load0 = 1'b1;
        tick();
        reset = 1'b0;
        load0 = 1'b0;
        exp_q.delete();
        chk("mrst_busy", busy0, 0);
        chk("mrst_rdy", rdy0, 0);
        chk("mrst_clk", aclk0, 0);
        chk("mrst_dat", adat0, 0);
        chk("mrst_done", fd0, 0);
        chk("mrst_ovr", ovr0, 0);
        repeat (3) tick();
        chk("rst_load_ign", busy0, 0);
        f0 = frames;
        rnd_ch();
        send0();
        wait_frames(f0 + 1, 600);
        chk("post_rst_q", exp_q.size(), 0);

        // Load coincident with frame_done, pending empty
        f0 = frames;
        o0 = n_ovr;
        rnd_ch();
        n = cyc;
        send0();
        while (cyc < n + 389) tick();
        chk("done_pulse", fd0, 1);
        rnd_ch();
        push_frame(frame_of());
        load0 = 1'b1;
        tick();
        load0 = 1'b0;
        chk("imm_rdy", rdy0, 1);
        chk("imm_busy", busy0, 1);
        wait_frames(f0 + 2, 800);
        chk("imm_ovr", n_ovr, o0);
        chk("imm_q", exp_q.size(), 0);

        // HALF_DIV=3, READY_CYC=1 instance
        rnd_ch();
        f = frame_of();
        n = cyc;
        load1 = 1'b1;
        tick();
        load1 = 1'b0;
        nr = 0; last_rise = 0; bad_edge = 0; done_at = 0;
        pc = 1'b0; pr = 1'b0; pd = 1'b0;
        for (int j = 0; j < 1300 && done_at == 0; j++) begin
            if (aclk1 && !pc) begin
                if (nr == 0) chk("h3_first_rise", cyc - n, 5);
                else         chk("h3_period", cyc - last_rise, 6);
                if (nr < 192) chk("h3_bit", adat1, f[191 - nr]);
                last_rise = cyc;
                nr++;
            end
            if (adat1 != pd && !(pc && !aclk1) && !(pr && !rdy1)) bad_edge++;
            if (fd1) done_at = cyc;
            pc = aclk1;
            pr = rdy1;
            pd = adat1;
            if (done_at == 0) tick();
        end
        chk("h3_rises", nr, 192);
        chk("h3_len", done_at - n, 1154);
        chk("h3_edges", bad_edge, 0);
        chk("h3_ovr", ovr1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
